// File: rtl/uart_joypad_decoder_pkg.sv
// -----------------------------------------------------------------------------
// uart_joypad_decoder_pkg
// Shared definitions for the UART joypad frame decoder:
//   - state_t           : frame parser states
//   - DEFAULT_SYNC_BYTE : frame start marker
//   - BTN_*             : bit positions of the NES buttons in a pad byte
//   - us_to_cycles / ms_to_cycles : convert time budgets to clock cycles
// -----------------------------------------------------------------------------
package uart_joypad_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAD1  = 3'd1,
    ST_PAD2  = 3'd2,
    ST_CHECK = 3'd3,
    ST_APPLY = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Button bit positions inside a pad byte (1 = pressed)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Division first keeps the intermediate product inside 32 bits for
  // realistic clock frequencies.
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/uart_joypad_decoder_timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// Saturating up-counter with terminal-count flag.
//   clk_i     : clock
//   rst_n_i   : synchronous reset, active-low (count -> 0)
//   clear_i   : force count to 0 (has priority over enable_i)
//   enable_i  : advance count by one, holding at COUNT-1
//   tc_o      : high while count == COUNT-1
// -----------------------------------------------------------------------------
module timeout_counter #(
  parameter int COUNT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i && (r_count != LAST)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign tc_o = (r_count == LAST);

endmodule

// File: rtl/uart_joypad_decoder.sv
// -----------------------------------------------------------------------------
// uart_joypad_decoder
// Parses 4-byte frames {SYNC, PAD1, PAD2, CHK} from the UART receiver into two
// registered NES joypad vectors. CHK must equal SYNC ^ PAD1 ^ PAD2.
//
// Handshake: a byte is transferred on a rising edge where data_valid_i and
// ready_o are both high. ready_o depends only on the parser state and is low
// solely during the single APPLY cycle; the source must hold data_i stable
// while data_valid_i is high and ready_o is low.
//
// Ports:
//   clk_i          : clock
//   rst_n_i        : synchronous reset, active-low
//   data_i         : received byte
//   data_valid_i   : data_i valid
//   ready_o        : decoder can accept a byte
//   joypad_1_o     : pad 1 buttons (1 = pressed)
//   joypad_2_o     : pad 2 buttons (1 = pressed)
//   joypad_valid_o : one-cycle pulse when pads are updated by a good frame
//   frame_error_o  : one-cycle pulse on checksum error or intra-frame timeout
//   dbg_state_o    : current parser state (observation only)
// -----------------------------------------------------------------------------
module uart_joypad_decoder
  import uart_joypad_decoder_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 115_200_000,
  parameter int         TIMEOUT_US  = 1000,
  parameter int         RELEASE_MS  = 100,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       ready_o,
  output logic [7:0] joypad_1_o,
  output logic [7:0] joypad_2_o,
  output logic       joypad_valid_o,
  output logic       frame_error_o,
  output state_t     dbg_state_o
);

  localparam int TO_CYCLES  = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int REL_CYCLES = ms_to_cycles(CLK_FREQ_HZ, RELEASE_MS);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_accept;
  logic       w_latch_pad1;
  logic       w_latch_pad2;
  logic       w_error;
  logic       w_commit;
  logic       w_in_frame;
  logic       w_to_clear;
  logic       w_to_tc;
  logic       w_rel_tc;
  logic [7:0] r_pad1;
  logic [7:0] r_pad2;
  logic [7:0] r_joypad_1;
  logic [7:0] r_joypad_2;
  logic       r_joypad_valid;
  logic       r_frame_error;

  assign ready_o  = (r_state != ST_APPLY);
  assign w_accept = data_valid_i & ready_o;

  // ---------------------------------------------------------------------------
  // Parser FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In PAD1/PAD2/CHECK an accepted byte takes precedence over the timeout
  // terminal count, so a byte arriving on the last allowed cycle is kept.
  always_comb begin
    w_state_next = r_state;
    w_latch_pad1 = 1'b0;
    w_latch_pad2 = 1'b0;
    w_error      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Non-sync bytes are dropped silently while hunting for a frame start
        if (w_accept && (data_i == SYNC_BYTE)) begin
          w_state_next = ST_PAD1;
        end
      end
      ST_PAD1: begin
        if (w_accept) begin
          w_latch_pad1 = 1'b1;
          w_state_next = ST_PAD2;
        end else if (w_to_tc) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_PAD2: begin
        if (w_accept) begin
          w_latch_pad2 = 1'b1;
          w_state_next = ST_CHECK;
        end else if (w_to_tc) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (w_accept) begin
          if (data_i == (SYNC_BYTE ^ r_pad1 ^ r_pad2)) begin
            w_state_next = ST_APPLY;
          end else begin
            w_error      = 1'b1;
            w_state_next = ST_IDLE;
          end
        end else if (w_to_tc) begin
          w_error      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_APPLY: begin
        w_commit     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timers
  // ---------------------------------------------------------------------------
  assign w_in_frame = (r_state == ST_PAD1) || (r_state == ST_PAD2) ||
                      (r_state == ST_CHECK);
  assign w_to_clear = w_accept || !w_in_frame;

  timeout_counter #(
    .COUNT (TO_CYCLES)
  ) u_intra_frame_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (w_to_clear),
    .enable_i (w_in_frame),
    .tc_o     (w_to_tc)
  );

  // Runs freely and saturates; only a committed frame restarts it.
  timeout_counter #(
    .COUNT (REL_CYCLES)
  ) u_release_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (w_commit),
    .enable_i (1'b1),
    .tc_o     (w_rel_tc)
  );

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pad1         <= '0;
      r_pad2         <= '0;
      r_joypad_1     <= '0;
      r_joypad_2     <= '0;
      r_joypad_valid <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_joypad_valid <= w_commit;
      r_frame_error  <= w_error;
      if (w_latch_pad1) begin
        r_pad1 <= data_i;
      end
      if (w_latch_pad2) begin
        r_pad2 <= data_i;
      end
      // A commit beats a coincident release. While the watchdog sits
      // saturated the pads are re-cleared every cycle, which is invisible
      // outside and needs no extra "already released" flag.
      if (w_commit) begin
        r_joypad_1 <= r_pad1;
        r_joypad_2 <= r_pad2;
      end else if (w_rel_tc) begin
        r_joypad_1 <= '0;
        r_joypad_2 <= '0;
      end
    end
  end

  assign joypad_1_o     = r_joypad_1;
  assign joypad_2_o     = r_joypad_2;
  assign joypad_valid_o = r_joypad_valid;
  assign frame_error_o  = r_frame_error;
  assign dbg_state_o    = r_state;

endmodule
